// File: rtl/rom_loader_pkg.sv
// Shared constants and FSM encoding for the serial program-memory loader.
// Imported by rom_loader.
package rom_loader_pkg;

   localparam int unsigned ByteW = 8;
   localparam int unsigned WordW = 32;
   localparam int unsigned AddrW = 11;
   localparam int unsigned LenW  = 16;

   localparam logic [ByteW-1:0] SyncByte = 8'hA5;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLenHi = 3'd1,
      StLenLo = 3'd2,
      StData  = 3'd3,
      StCsum  = 3'd4
   } loader_state_e;

endpackage

// File: rtl/rom_loader.sv
// Byte-stream frame loader: A5, LEN_HI, LEN_LO, 4*LEN data bytes, XOR checksum.
// Assembled big-endian words are written to external program memory via we/addr/wdata.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000000,
   parameter int unsigned DEPTH   = 2048
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [ByteW-1:0] rx_data,
   output logic             we,
   output logic [AddrW-1:0] addr,
   output logic [WordW-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned GapW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   loader_state_e    state_q, state_d;
   logic [LenW-1:0]  len_q, len_d;
   logic [WordW-1:0] shift_q, shift_d;
   logic [1:0]       byte_q, byte_d;
   logic [LenW-1:0]  word_q, word_d;
   logic [ByteW-1:0] csum_q, csum_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic             we_q, we_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [WordW-1:0] wdata_q, wdata_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [LenW-1:0]  len_full;
   logic [WordW-1:0] word_full;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      word_d    = word_q;
      csum_d    = csum_q;
      gap_d     = gap_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      done_d    = done_q;
      err_d     = err_q;
      len_full  = {len_q[ByteW-1:0], rx_data};
      word_full = {shift_q[WordW-ByteW-1:0], rx_data};

      // Inter-byte watchdog; rx_valid and expiry are mutually exclusive.
      if (state_q != StIdle) begin
         if (rx_valid) begin
            gap_d = '0;
         end else if (gap_q == GapW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            done_d  = 1'b0;
            gap_d   = '0;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (rx_valid && rx_data == SyncByte) begin
               state_d = StLenHi;
               done_d  = 1'b0;
               err_d   = 1'b0;
               addr_d  = '0;
               word_d  = '0;
               byte_d  = '0;
               csum_d  = '0;
               gap_d   = '0;
            end
         end
         StLenHi: begin
            if (rx_valid) begin
               len_d   = {{(LenW-ByteW){1'b0}}, rx_data};
               state_d = StLenLo;
            end
         end
         StLenLo: begin
            if (rx_valid) begin
               len_d = len_full;
               if (len_full == '0 || 32'(len_full) > DEPTH) begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (rx_valid) begin
               shift_d = word_full;
               csum_d  = csum_q ^ rx_data;
               byte_d  = byte_q + 2'd1;
               if (byte_q == 2'd3) begin
                  we_d    = 1'b1;
                  wdata_d = word_full;
                  addr_d  = word_q[AddrW-1:0];
                  word_d  = word_q + 16'd1;
                  if (word_q + 16'd1 == len_q) state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (rx_valid) begin
               state_d = StIdle;
               if (rx_data == csum_q) done_d = 1'b1;
               else                   err_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         len_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
         gap_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
         gap_q   <= gap_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign we    = we_q;
   assign addr  = addr_q;
   assign wdata = wdata_q;
   assign busy  = (state_q != StIdle);
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: good/bad frames, length limits, timeout,
// mid-frame reset and a full-depth back-to-back frame.
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        we;
   logic [10:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [10:0] wr_addr[$];
   logic [31:0] wr_data[$];

   rom_loader #(
      .TIMEOUT(100),
      .DEPTH  (2048)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rx_valid(rx_valid),
      .rx_data (rx_data),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we) begin
         wr_addr.push_back(addr);
         wr_data.push_back(wdata);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called with stimulus aligned at posedge+1; consecutive calls keep rx_valid high.
   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[31:24]);
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   function automatic logic [31:0] b2b_word(input int i);
      if (i == 0) return 32'hA5A5A5A5;
      return (32'(i) * 32'h01010F1D) ^ 32'h5A3C0000;
   endfunction

   initial begin
      logic [7:0]  cs;
      logic [31:0] w;
      int          bad;

      // Reset state
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_wdata", wdata, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Two-word good frame; XOR of the eight data bytes is 0x00
      clear_log();
      send(8'hA5);
      check("f1_busy_mid", 32'(busy), 32'd1);
      send(8'h00);
      send(8'h02);
      send_word(32'h12345678);
      send_word(32'h9ABCDEF0);
      send(8'h00);
      settle();
      check("f1_nwr", 32'(wr_addr.size()), 32'd2);
      check("f1_addr0", 32'(wr_addr[0]), 32'd0);
      check("f1_data0", wr_data[0], 32'h12345678);
      check("f1_addr1", 32'(wr_addr[1]), 32'd1);
      check("f1_data1", wr_data[1], 32'h9ABCDEF0);
      check("f1_done", 32'(done), 32'd1);
      check("f1_err", 32'(err), 32'd0);
      check("f1_busy", 32'(busy), 32'd0);

      // Same frame with checksum 0x08: both words land, then err
      clear_log();
      send(8'hA5);
      send(8'h00);
      send(8'h02);
      send_word(32'h12345678);
      send_word(32'h9ABCDEF0);
      send(8'h08);
      settle();
      check("f2_nwr", 32'(wr_addr.size()), 32'd2);
      check("f2_done", 32'(done), 32'd0);
      check("f2_err", 32'(err), 32'd1);

      // Non-sync byte in idle is ignored
      send(8'h3C);
      settle();
      check("idle_ignore_busy", 32'(busy), 32'd0);

      // LEN = 0
      clear_log();
      send(8'hA5);
      send(8'h00);
      send(8'h00);
      settle();
      check("len0_err", 32'(err), 32'd1);
      check("len0_nwr", 32'(wr_addr.size()), 32'd0);
      check("len0_busy", 32'(busy), 32'd0);

      // LEN = 0x0801 > DEPTH
      clear_log();
      send(8'hA5);
      send(8'h08);
      send(8'h01);
      send_word(32'h01020304);
      settle();
      check("lenbig_err", 32'(err), 32'd1);
      check("lenbig_nwr", 32'(wr_addr.size()), 32'd0);

      // One word, wrong checksum (correct would be 0x44)
      clear_log();
      send(8'hA5);
      send(8'h00);
      send(8'h01);
      send_word(32'h11223344);
      send(8'h45);
      settle();
      check("bad_cs_nwr", 32'(wr_addr.size()), 32'd1);
      check("bad_cs_addr", 32'(wr_addr[0]), 32'd0);
      check("bad_cs_data", wr_data[0], 32'h11223344);
      check("bad_cs_err", 32'(err), 32'd1);
      check("bad_cs_done", 32'(done), 32'd0);

      // Timeout after two data bytes: err exactly 100 cycles after the last byte
      clear_log();
      send(8'hA5);
      send(8'h00);
      send(8'h01);
      check("to_err_clr", 32'(err), 32'd0);
      send(8'hDE);
      send(8'hAD);
      repeat (99) @(posedge clk);
      #1;
      check("to_err_early", 32'(err), 32'd0);
      check("to_busy_early", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("to_err", 32'(err), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_nwr", 32'(wr_addr.size()), 32'd0);

      // Reset after third data byte, then a good one-word frame
      clear_log();
      send(8'hA5);
      send(8'h00);
      send(8'h01);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      reset = 1'b0;
      #3;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      send(8'hA5);
      send(8'h00);
      send(8'h01);
      send_word(32'hAABBCCDD);
      send(8'h00);
      settle();
      check("mid_rst_nwr", 32'(wr_addr.size()), 32'd1);
      check("mid_rst_addr", 32'(wr_addr[0]), 32'd0);
      check("mid_rst_data", wr_data[0], 32'hAABBCCDD);
      check("mid_rst_done", 32'(done), 32'd1);

      // Full-depth frame, one byte per cycle, data containing 0xA5 bytes
      clear_log();
      cs = 8'h00;
      send(8'hA5);
      send(8'h08);
      send(8'h00);
      for (int i = 0; i < 2048; i++) begin
         w = b2b_word(i);
         cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send_word(w);
      end
      send(cs);
      settle();
      check("b2b_nwr", 32'(wr_addr.size()), 32'd2048);
      bad = 0;
      for (int i = 0; i < wr_addr.size(); i++) begin
         if (wr_addr[i] !== 11'(i) || wr_data[i] !== b2b_word(i)) bad++;
      end
      check("b2b_bad_words", 32'(bad), 32'd0);
      check("b2b_last_addr", 32'(wr_addr[2047]), 32'd2047);
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_err", 32'(err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
